// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed when Start is accepted and committed after a modelled latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MD_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               divz_q,   divz_d;
    logic [31:0]        hi_q,     hi_d;
    logic [31:0]        lo_q,     lo_d;
    logic [31:0]        hi_tmp_q, hi_tmp_d;
    logic [31:0]        lo_tmp_q, lo_tmp_d;

    logic [63:0] prod;
    logic        signed_div;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, quot, rem;

    // Combinational arithmetic; divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        if (MD_Op == OP_MULT) begin
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else begin
            prod = {32'b0, A} * {32'b0, B};
        end
        signed_div = (MD_Op == OP_DIV);
        abs_a      = (signed_div && A[31]) ? (~A + 32'd1) : A;
        abs_b      = (signed_div && B[31]) ? (~B + 32'd1) : B;
        div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq         = abs_a / div_b;
        ur         = abs_a % div_b;
        quot       = (signed_div && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
        rem        = (signed_div && A[31]) ? (~ur + 32'd1) : ur;
    end

    // Next-state logic: accept requests in IDLE, count down and commit in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MD_Op)
                        OP_MULT, OP_MULTU: begin
                            hi_tmp_d = prod[63:32];
                            lo_tmp_d = prod[31:0];
                            divz_d   = 1'b0;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            hi_tmp_d = rem;
                            lo_tmp_d = quot;
                            divz_d   = (B == 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!divz_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit latency, arithmetic, mthi/mtlo and reset behaviour.
module tb_md_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MD_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MD_Op (MD_Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, check Busy/HI/LO through the run, then the committed values.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic [31:0] ph, input logic [31:0] pl);
        Start = 1'b1; MD_Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_hi_hold"}, HI, ph);
            chk({tag, "_lo_hold"}, LO, pl);
            @(negedge Clk);
        end
        chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
        chk({tag, "_hi"}, HI, eh);
        chk({tag, "_lo"}, LO, el);
    endtask

    // Single-cycle mthi/mtlo/no-op request.
    task automatic move_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] eh, input logic [31:0] el);
        Start = 1'b1; MD_Op = op; A = a; B = 32'd0;
        @(negedge Clk);
        Start = 1'b0;
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_hi"}, HI, eh);
        chk({tag, "_lo"}, LO, el);
        @(negedge Clk);
        chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MD_Op = 3'b111; A = '0; B = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        run_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd5, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0, 32'h0);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5,
               32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFE);

        move_op("mthi", 3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFD);
        move_op("mtlo", 3'b101, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
        move_op("noop6", 3'b110, 32'h0000_0055, 32'hDEAD_BEEF, 32'h1234_5678);
        move_op("noop7", 3'b111, 32'h0000_0066, 32'hDEAD_BEEF, 32'h1234_5678);
        move_op("mthi11", 3'b100, 32'h0000_0011, 32'h0000_0011, 32'h1234_5678);
        move_op("mtlo22", 3'b101, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);

        run_op("divu_z", 3'b011, 32'h0000_0064, 32'd0, 10,
               32'h0000_0011, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0000, 32'h8000_0000, 32'h0000_0011, 32'h0000_0022);
        run_op("divu", 3'b011, 32'd100, 32'd7, 10,
               32'd2, 32'd14, 32'h0000_0000, 32'h8000_0000);

        // Start pulses during RUN must be ignored.
        Start = 1'b1; MD_Op = 3'b000; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ign_busy", 32'(Busy), 32'd1);
            chk("ign_hi_hold", HI, 32'd2);
            chk("ign_lo_hold", LO, 32'd14);
            if (i == 1) begin
                Start = 1'b1; MD_Op = 3'b000; A = 32'd1; B = 32'd1;
            end else if (i == 2) begin
                Start = 1'b1; MD_Op = 3'b100; A = 32'h0000_0BAD;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        chk("ign_busy_done", 32'(Busy), 32'd0);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'd12);
        @(negedge Clk);
        chk("ign_busy_stays", 32'(Busy), 32'd0);
        chk("ign_hi_stable", HI, 32'd0);
        chk("ign_lo_stable", LO, 32'd12);

        // Reset in the third cycle of a divide aborts without committing.
        Start = 1'b1; MD_Op = 3'b010; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        chk("abort_busy_run", 32'(Busy), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) @(negedge Clk);
        chk("abort_busy_late", 32'(Busy), 32'd0);
        chk("abort_hi_late", HI, 32'd0);
        chk("abort_lo_late", LO, 32'd0);

        // Reset wins over a simultaneous Start.
        Reset = 1'b1; Start = 1'b1; MD_Op = 3'b100; A = 32'h0000_0005;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;
        chk("rst_start_hi", HI, 32'd0);
        chk("rst_start_busy", 32'(Busy), 32'd0);
        Reset = 1'b1; Start = 1'b1; MD_Op = 3'b000; A = 32'd2; B = 32'd3;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clk);
        chk("rst_start_mult_busy", 32'(Busy), 32'd0);
        chk("rst_start_mult_lo", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
